// File: rtl/multi_dma_pkg.sv
// Shared constants and helpers for the multi-channel burst read DMA.
package multi_dma_pkg;

  localparam int BLEN_VCI = 0;
  localparam int BLEN_AXI = 1;

  localparam int CST_BUSY_LSB = 0;
  localparam int CST_TAG_LSB  = 8;
  localparam int CST_ERR_BIT  = 31;

  function automatic int burst_bytes(input int bl, input int al);
    return 1 << (bl + al);
  endfunction

  function automatic int biu_len_val(input int bl, input int blen_type);
    return (blen_type == BLEN_AXI) ? ((1 << bl) - 1) : (1 << bl);
  endfunction

endpackage

// File: rtl/multi_dma_rc_tag.sv
// Tag queue: records the owning channel of each outstanding burst, in issue order.
module multi_dma_rc_tag #(
  parameter int OW = 2,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [CW-1:0] data_i,
  input  logic          pop_i,
  output logic [CW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [OW:0]   level_o
);

  localparam int DEPTH = 1 << OW;

  logic [CW-1:0] mem_q [DEPTH];
  logic [OW-1:0] wr_q;
  logic [OW-1:0] rd_q;
  logic [OW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (OW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + OW'(1);
      end
      if (do_pop) rd_q <= rd_q + OW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (OW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (OW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/multi_dma_rc.sv
// Multi-channel burst read DMA: round-robin burst requests gated by FIFO room,
// with returning beats steered to the owning channel's FIFO through a tag queue.
module multi_dma_rc
  import multi_dma_pkg::*;
#(
  parameter int AL        = 2,
  parameter int AW        = 32,
  parameter int BL        = 4,
  parameter int FW        = 6,
  parameter int CH        = 3,
  parameter int CW        = $clog2(CH),
  parameter int OW        = 2,
  parameter int BLEN_TYPE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH-1:0]           pio_adr_we,
  input  logic [CH-1:0]           pio_len_we,
  input  logic [31:0]             pio_d,
  output logic [CH-1:0][31:0]     pio_adr,
  output logic [CH-1:0][31:0]     pio_len,
  output logic [31:0]             pio_cst,
  input  logic [CH-1:0][FW:0]     dff_cnt,
  output logic                    dff_we,
  output logic [CW-1:0]           dff_ch,
  output logic [CH-1:0]           done,
  output logic [AW-1:0]           biu_adr,
  output logic [BL-BLEN_TYPE:0]   biu_len,
  output logic [CW-1:0]           biu_ch,
  output logic                    biu_val,
  input  logic                    biu_rdy,
  input  logic                    rsp_val
);

  localparam int              LB      = BL + AL;
  localparam logic [31:0]     BURST_B = 32'(burst_bytes(BL, AL));
  localparam logic [FW+1:0]   BURST_W = (FW+2)'(1 << BL);
  localparam logic [FW+1:0]   FIFO_SZ = (FW+2)'(1 << FW);
  localparam logic [FW:0]     RSV_INC = (FW+1)'(1 << BL);
  localparam logic [OW+1:0]   TAGS    = (OW+2)'(1 << OW);

  logic [CH-1:0][31:0]   adr_q;
  logic [CH-1:0][31:0]   len_q;
  logic [CH-1:0][FW:0]   rsv_q;
  logic                  biu_val_q;
  logic [AW-1:0]         biu_adr_q;
  logic [CW-1:0]         biu_ch_q;
  logic [CW-1:0]         ptr_q;
  logic [BL-1:0]         beat_q;
  logic                  err_q;

  logic                  accept;
  logic                  grant_ok;
  logic [CH-1:0]         hit;
  logic [CH-1:0]         rsp_hit;
  logic [CH-1:0][31:0]   adr_eff;
  logic [CH-1:0][31:0]   len_eff;
  logic [CH-1:0][FW+1:0] room;
  logic [CH-1:0]         elig;
  logic [OW+1:0]         lvl_eff;
  logic                  found;
  logic [CW-1:0]         win;

  logic                  tag_pop;
  logic [CW-1:0]         tag_head;
  logic                  tag_full;
  logic                  tag_empty;
  logic [OW:0]           tag_level;
  logic                  unused_pio_lsb;

  assign unused_pio_lsb = ^{pio_d[LB-1:0], tag_full};

  assign accept   = biu_val_q & biu_rdy;
  assign grant_ok = ~biu_val_q | biu_rdy;
  assign dff_we   = rsp_val & ~tag_empty;
  assign dff_ch   = tag_head;
  assign tag_pop  = dff_we & (beat_q == '1);

  multi_dma_rc_tag #(.OW(OW), .CW(CW)) u_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .data_i  (biu_ch_q),
    .pop_i   (tag_pop),
    .head_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .level_o (tag_level)
  );

  // Eligibility sees the state as it will be after the pending accept lands.
  always_comb begin
    lvl_eff = {1'b0, tag_level} + (OW+2)'(accept) - (OW+2)'(tag_pop);
    for (int i = 0; i < CH; i++) begin
      hit[i]     = accept && (biu_ch_q == CW'(i));
      rsp_hit[i] = dff_we && (dff_ch == CW'(i));
      len_eff[i] = hit[i] ? (len_q[i] - BURST_B) : len_q[i];
      adr_eff[i] = hit[i] ? (adr_q[i] + BURST_B) : adr_q[i];
      room[i]    = {1'b0, dff_cnt[i]} + {1'b0, rsv_q[i]}
                 + (hit[i] ? BURST_W : '0) + BURST_W;
      elig[i]    = (len_eff[i] != 32'd0) && (room[i] <= FIFO_SZ) && (lvl_eff < TAGS);
    end
  end

  always_comb begin
    int idx;
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    for (int k = 1; k <= CH; k++) begin
      idx = (int'(ptr_q) + k) % CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = CW'(idx);
      end
    end
  end

  // Request register: held until accepted, reloaded on the accepting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      biu_val_q <= 1'b0;
      biu_adr_q <= '0;
      biu_ch_q  <= '0;
      ptr_q     <= CW'(CH - 1);
    end else if (grant_ok) begin
      biu_val_q <= found;
      if (found) begin
        biu_adr_q <= AW'(adr_eff[win]);
        biu_ch_q  <= win;
        ptr_q     <= win;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q  <= '0;
      len_q  <= '0;
      rsv_q  <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (pio_adr_we[i])  adr_q[i] <= {pio_d[31:LB], {LB{1'b0}}};
        else if (hit[i])    adr_q[i] <= adr_q[i] + BURST_B;
        if (pio_len_we[i])  len_q[i] <= {pio_d[31:LB], {LB{1'b0}}};
        else if (hit[i])    len_q[i] <= len_q[i] - BURST_B;
        rsv_q[i] <= rsv_q[i] + (hit[i] ? RSV_INC : '0)
                             - (rsp_hit[i] ? (FW+1)'(1) : '0);
      end
      if (dff_we) beat_q <= beat_q + BL'(1);
      if (rsp_val && tag_empty) err_q <= 1'b1;
    end
  end

  always_comb begin
    pio_cst = '0;
    for (int i = 0; i < CH; i++) begin
      done[i] = (len_q[i] == 32'd0) && (rsv_q[i] == '0)
             && !(biu_val_q && (biu_ch_q == CW'(i)));
    end
    pio_cst[CST_BUSY_LSB +: CH]    = ~done;
    pio_cst[CST_TAG_LSB +: OW + 1] = tag_level;
    pio_cst[CST_ERR_BIT]           = err_q;
  end

  assign pio_adr = adr_q;
  assign pio_len = len_q;
  assign biu_val = biu_val_q;
  assign biu_adr = biu_adr_q;
  assign biu_ch  = biu_ch_q;
  assign biu_len = (BL - BLEN_TYPE + 1)'(biu_len_val(BL, BLEN_TYPE));

endmodule

// File: tb/tb_multi_dma_rc.sv
// Directed bench for multi_dma_rc with default parameters (64-byte bursts, 3 channels, 4 tags).
module tb_multi_dma_rc;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [2:0]        pio_adr_we;
  logic [2:0]        pio_len_we;
  logic [31:0]       pio_d;
  logic [2:0][31:0]  pio_adr;
  logic [2:0][31:0]  pio_len;
  logic [31:0]       pio_cst;
  logic [2:0][6:0]   dff_cnt;
  logic              dff_we;
  logic [1:0]        dff_ch;
  logic [2:0]        done;
  logic [31:0]       biu_adr;
  logic [4:0]        biu_len;
  logic [1:0]        biu_ch;
  logic              biu_val;
  logic              biu_rdy;
  logic              rsp_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_dma_rc dut (
    .clk(clk), .rst_n(rst_n),
    .pio_adr_we(pio_adr_we), .pio_len_we(pio_len_we), .pio_d(pio_d),
    .pio_adr(pio_adr), .pio_len(pio_len), .pio_cst(pio_cst),
    .dff_cnt(dff_cnt), .dff_we(dff_we), .dff_ch(dff_ch), .done(done),
    .biu_adr(biu_adr), .biu_len(biu_len), .biu_ch(biu_ch),
    .biu_val(biu_val), .biu_rdy(biu_rdy), .rsp_val(rsp_val)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    pio_adr_we = 3'b000;
    pio_len_we = 3'b000;
    pio_d      = 32'h0;
    dff_cnt    = '0;
    biu_rdy    = 1'b0;
    rsp_val    = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic wr(input logic [2:0] awe, input logic [2:0] lwe, input logic [31:0] d);
    pio_adr_we = awe;
    pio_len_we = lwe;
    pio_d      = d;
    cyc(1);
    pio_adr_we = 3'b000;
    pio_len_we = 3'b000;
  endtask

  initial begin
    #1;
    // Reset state
    do_reset();
    check("rst_val", biu_val, 1'b0);
    check("rst_done", done, 3'b111);
    check("rst_cst", pio_cst, 32'h0);
    check("rst_dffwe", dff_we, 1'b0);
    check("rst_adr0", pio_adr[0], 32'h0);

    // Single channel, two bursts, drain 32 beats
    biu_rdy = 1'b1;
    wr(3'b001, 3'b000, 32'h0000_1023);
    check("adr_lsb_forced", pio_adr[0], 32'h0000_1000);
    wr(3'b000, 3'b001, 32'h0000_0080);
    cyc(1);
    check("t1_val0", biu_val, 1'b1);
    check("t1_adr0", biu_adr, 32'h0000_1000);
    check("t1_ch0", biu_ch, 2'd0);
    check("t1_len", biu_len, 5'd16);
    cyc(1);
    check("t1_val1", biu_val, 1'b1);
    check("t1_adr1", biu_adr, 32'h0000_1040);
    cyc(1);
    check("t1_idle", biu_val, 1'b0);
    check("t1_len0", pio_len[0], 32'h0);
    check("t1_adrend", pio_adr[0], 32'h0000_1080);
    check("t1_cst", pio_cst, 32'h0000_0201);
    check("t1_done_busy", done, 3'b110);
    for (int i = 0; i < 32; i++) begin
      rsp_val = 1'b1;
      #1;
      check("t1_dffwe", dff_we, 1'b1);
      check("t1_dffch", dff_ch, 2'd0);
      if (i == 31) check("t1_done_late", done, 3'b110);
      cyc(1);
    end
    rsp_val = 1'b0;
    #1;
    check("t1_done", done, 3'b111);
    check("t1_cst_end", pio_cst, 32'h0);

    // FIFO room gating on channel 1
    do_reset();
    biu_rdy = 1'b1;
    dff_cnt[1] = 7'd49;
    wr(3'b000, 3'b010, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t2_blocked", biu_val, 1'b0);
    end
    check("t2_done", done, 3'b101);
    dff_cnt[1] = 7'd48;
    cyc(1);
    check("t2_val", biu_val, 1'b1);
    check("t2_ch", biu_ch, 2'd1);
    check("t2_adr", biu_adr, 32'h0);
    cyc(1);
    check("t2_len", pio_len[1], 32'h0000_00C0);
    check("t2_adrnext", pio_adr[1], 32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      check("t2_noreq", biu_val, 1'b0);
      cyc(1);
    end

    // Round-robin, stall stability, tag-queue limit
    do_reset();
    wr(3'b010, 3'b000, 32'h0000_2000);
    wr(3'b100, 3'b000, 32'h0000_4000);
    wr(3'b000, 3'b111, 32'h0000_1000);
    cyc(1);
    check("t3_val", biu_val, 1'b1);
    check("t3_ch0", biu_ch, 2'd0);
    check("t3_adr0", biu_adr, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("t3_hold_val", biu_val, 1'b1);
      check("t3_hold_ch", biu_ch, 2'd0);
      check("t3_hold_adr", biu_adr, 32'h0);
    end
    biu_rdy = 1'b1;
    cyc(1);
    check("t3_ch1", biu_ch, 2'd1);
    check("t3_adr1", biu_adr, 32'h0000_2000);
    cyc(1);
    check("t3_ch2", biu_ch, 2'd2);
    check("t3_adr2", biu_adr, 32'h0000_4000);
    cyc(1);
    check("t3_ch0b", biu_ch, 2'd0);
    check("t3_adr0b", biu_adr, 32'h0000_0040);
    cyc(1);
    check("t4_full_val", biu_val, 1'b0);
    check("t4_full_cst", pio_cst, 32'h0000_0407);
    cyc(1);
    check("t4_full_val2", biu_val, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rsp_val = 1'b1;
      #1;
      check("t4_dffch", dff_ch, 2'd0);
      cyc(1);
    end
    rsp_val = 1'b0;
    check("t4_refill_val", biu_val, 1'b1);
    check("t4_refill_ch", biu_ch, 2'd1);
    check("t4_refill_adr", biu_adr, 32'h0000_2040);
    check("t4_refill_cst", pio_cst, 32'h0000_0307);

    // Response with empty tag queue sets sticky error
    do_reset();
    rsp_val = 1'b1;
    #1;
    check("t5_dffwe", dff_we, 1'b0);
    cyc(1);
    check("t5_err", pio_cst, 32'h8000_0000);
    rsp_val = 1'b0;
    cyc(3);
    check("t5_sticky", pio_cst, 32'h8000_0000);
    rst_n = 1'b0;
    #1;
    check("t5_rst_clr", pio_cst, 32'h0);

    // Reset asserted mid-burst
    do_reset();
    biu_rdy = 1'b1;
    wr(3'b000, 3'b001, 32'h0000_0040);
    cyc(1);
    check("t6_val", biu_val, 1'b1);
    cyc(1);
    check("t6_acc", biu_val, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rsp_val = 1'b1;
      cyc(1);
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_val", biu_val, 1'b0);
    check("t6_rst_done", done, 3'b111);
    check("t6_rst_dffwe", dff_we, 1'b0);
    rsp_val = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check("t6_cst", pio_cst, 32'h0);
    check("t6_done", done, 3'b111);
    check("t6_val_post", biu_val, 1'b0);
    check("t6_len", pio_len[0], 32'h0);
    rsp_val = 1'b1;
    cyc(1);
    rsp_val = 1'b0;
    check("t6_late_err", pio_cst, 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
